// File: rtl/pwm_pkg.sv
// Shared types and default sizes for the multi-channel dead-time PWM.
//   pwm_mode_t : counting mode latched at each period boundary
//   pwm_dir_t  : counter direction (centre-aligned mode)
//   dt_state_t : per-channel dead-time state machine encoding
package pwm_pkg;

  localparam int unsigned PWM_WIDTH = 11;
  localparam int unsigned PWM_NCH   = 2;
  localparam int unsigned PWM_DT_W  = 6;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;

  typedef enum logic {UP, DOWN} pwm_dir_t;

  typedef enum logic [1:0] {OFF_BOTH, HI_ON, LO_ON, WAIT} dt_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel complementary output stage with dead-time insertion.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   en        : channel enable; low forces both outputs off and clears the counter
//   raw       : compare result for this channel (1 = high side wanted)
//   deadtime  : required raw stability, in clk cycles, before an output turns on
//   hi, lo    : registered high/low-side drives, never both 1
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int unsigned DT_W = PWM_DT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            raw,
  input  logic [DT_W-1:0] deadtime,
  output logic            hi,
  output logic            lo
);

  dt_state_t       state, state_nx;
  logic [DT_W-1:0] dcnt, dcnt_nx;
  logic            raw_q;
  logic            raw_edge;
  logic            restart;

  assign raw_edge = raw ^ raw_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF_BOTH;
      dcnt  <= '0;
      raw_q <= 1'b0;
      hi    <= 1'b0;
      lo    <= 1'b0;
    end else begin
      state <= state_nx;
      dcnt  <= dcnt_nx;
      raw_q <= raw;
      hi    <= (state_nx == HI_ON);
      lo    <= (state_nx == LO_ON);
    end
  end

  // Leaving OFF_BOTH is handled like a raw edge, so both sides wait the
  // dead-time after enable. dcnt counts cycles of stable raw including the
  // edge cycle itself, which gives turn-on deadtime+1 cycles after the change.
  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    restart  = 1'b0;
    if (!en) begin
      state_nx = OFF_BOTH;
      dcnt_nx  = '0;
    end else begin
      case (state)
        OFF_BOTH:     restart = 1'b1;
        HI_ON, LO_ON: restart = raw_edge;
        WAIT: begin
          if (raw_edge) begin
            restart = 1'b1;
          end else if (dcnt >= deadtime) begin
            state_nx = raw ? HI_ON : LO_ON;
            dcnt_nx  = '0;
          end else begin
            dcnt_nx = dcnt + DT_W'(1);
          end
        end
        default: state_nx = OFF_BOTH;
      endcase
      if (restart) begin
        if (deadtime == '0) begin
          state_nx = raw ? HI_ON : LO_ON;
          dcnt_nx  = '0;
        end else begin
          state_nx = WAIT;
          dcnt_nx  = DT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/pwm_multi_dt.sv
// Multi-channel PWM generator with programmable period, edge/centre-aligned
// counting, double-buffered duty/period and per-channel dead-time outputs.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   en            : run enable; low holds the counter at 0 and outputs off
//   center        : 0 = edge-aligned, 1 = centre-aligned (latched at boundary)
//   period_in/wr  : period shadow write
//   duty_in/wr    : packed per-channel duty shadow writes (ch i = [i*WIDTH +: WIDTH])
//   deadtime      : dead-time in cycles, shared by all channels
//   pwm_hi/pwm_lo : registered complementary drives per channel
//   period_start  : registered one-cycle pulse aligned with cnt==0 of each period
module pwm_multi_dt
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_WIDTH,
  parameter int unsigned NCH   = PWM_NCH,
  parameter int unsigned DT_W  = PWM_DT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 center,
  input  logic [WIDTH-1:0]     period_in,
  input  logic                 period_wr,
  input  logic [NCH*WIDTH-1:0] duty_in,
  input  logic [NCH-1:0]       duty_wr,
  input  logic [DT_W-1:0]      deadtime,
  output logic [NCH-1:0]       pwm_hi,
  output logic [NCH-1:0]       pwm_lo,
  output logic                 period_start
);

  logic [WIDTH-1:0] cnt, cnt_nx;
  pwm_dir_t         dir, dir_nx;
  pwm_mode_t        mode;
  logic             run_q;
  logic [WIDTH-1:0] period_act, period_sh;
  logic             bnd;
  logic [NCH-1:0]   raw;
  logic             en_dt;

  always_comb begin
    cnt_nx = cnt;
    dir_nx = dir;
    if (period_act == '0) begin
      cnt_nx = '0;
      dir_nx = UP;
    end else if (mode == PWM_EDGE) begin
      cnt_nx = (cnt >= period_act) ? '0 : cnt + WIDTH'(1);
    end else if (dir == UP) begin
      if (cnt >= period_act) begin
        cnt_nx = cnt - WIDTH'(1);
        dir_nx = DOWN;
      end else begin
        cnt_nx = cnt + WIDTH'(1);
      end
    end else begin
      cnt_nx = (cnt <= WIDTH'(1)) ? '0 : cnt - WIDTH'(1);
    end
  end

  // The first enabled cycle (run_q still low) is a boundary too, so a fresh
  // start always loads the shadows and emits period_start.
  assign bnd = !run_q || (cnt_nx == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      dir          <= UP;
      mode         <= PWM_EDGE;
      run_q        <= 1'b0;
      period_act   <= '1;
      period_start <= 1'b0;
    end else if (!en) begin
      cnt          <= '0;
      dir          <= UP;
      run_q        <= 1'b0;
      period_start <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      period_start <= bnd;
      if (bnd) begin
        cnt        <= '0;
        dir        <= UP;
        mode       <= center ? PWM_CENTER : PWM_EDGE;
        period_act <= period_sh;
      end else begin
        cnt <= cnt_nx;
        dir <= dir_nx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_sh <= '1;
    end else if (period_wr) begin
      period_sh <= period_in;
    end
  end

  // Output stages are held off during the start-up boundary cycle so they
  // first see raw computed from the freshly loaded duty.
  assign en_dt = en & run_q;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [WIDTH-1:0] duty_sh, duty_act;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_sh  <= '0;
        duty_act <= '0;
      end else begin
        if (duty_wr[g]) duty_sh <= duty_in[g*WIDTH +: WIDTH];
        if (en && bnd)  duty_act <= duty_sh;
      end
    end

    assign raw[g] = (cnt < duty_act);

    pwm_deadtime #(.DT_W(DT_W)) u_dt (
      .clk      (clk),
      .rst      (rst),
      .en       (en_dt),
      .raw      (raw[g]),
      .deadtime (deadtime),
      .hi       (pwm_hi[g]),
      .lo       (pwm_lo[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi_dt.sv
module tb_pwm_multi_dt;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        center;
  logic [10:0] period_in;
  logic        period_wr;
  logic [21:0] duty_in;
  logic [1:0]  duty_wr;
  logic [5:0]  deadtime;
  logic [1:0]  pwm_hi;
  logic [1:0]  pwm_lo;
  logic        period_start;

  int checks = 0;
  int errors = 0;

  pwm_multi_dt #(.WIDTH(11), .NCH(2), .DT_W(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .center       (center),
    .period_in    (period_in),
    .period_wr    (period_wr),
    .duty_in      (duty_in),
    .duty_wr      (duty_wr),
    .deadtime     (deadtime),
    .pwm_hi       (pwm_hi),
    .pwm_lo       (pwm_lo),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stop, load shadows, then enable; returns at j=0 (period_start cycle).
  task automatic restart(input logic [10:0] per, input logic [10:0] d0,
                         input logic [10:0] d1, input logic ctr, input logic [5:0] dt);
    en        = 1'b0;
    period_in = per;
    period_wr = 1'b1;
    duty_in   = {d1, d0};
    duty_wr   = 2'b11;
    center    = ctr;
    deadtime  = dt;
    step();
    period_wr = 1'b0;
    duty_wr   = 2'b00;
    en        = 1'b1;
    step();
  endtask

  task automatic test_reset();
    checks++;
    if ({pwm_hi, pwm_lo} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {pwm_hi, pwm_lo});
    end
    checks++;
    if (period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_period_start: got %b expected 0", period_start);
    end
  endtask

  task automatic test_edge();
    logic [3:0] got, exp_v;
    int p, ph;
    restart(11'd9, 11'd3, 11'd9, 1'b0, 6'd0);
    checks++;
    if ({period_start, pwm_hi[0], pwm_lo[0]} !== 3'b100) begin
      errors++;
      $display("FAIL edge_start: got %b expected 100", {period_start, pwm_hi[0], pwm_lo[0]});
    end
    for (int j = 1; j <= 30; j++) begin
      step();
      p  = j % 10;
      ph = (j - 1) % 10;
      exp_v = {p == 0, ph < 3, !(ph < 3), ph < 9};
      got   = {period_start, pwm_hi[0], pwm_lo[0], pwm_hi[1]};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL edge j=%0d: got %b expected %b", j, got, exp_v);
      end
    end
  endtask

  task automatic test_center();
    logic [2:0] got, exp_v;
    int p;
    restart(11'd8, 11'd4, 11'd0, 1'b1, 6'd2);
    for (int j = 1; j <= 40; j++) begin
      step();
      p = j % 16;
      if (j < 3) exp_v = {p == 0, 1'b0, 1'b0};
      else       exp_v = {p == 0, p <= 4, (p >= 7) && (p <= 13)};
      got = {period_start, pwm_hi[0], pwm_lo[0]};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL center j=%0d: got %b expected %b", j, got, exp_v);
      end
      checks++;
      if ((pwm_hi & pwm_lo) !== 2'b00) begin
        errors++;
        $display("FAIL center_overlap j=%0d: got %b expected 00", j, pwm_hi & pwm_lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dv[4] = '{3, 7, 7, 5};
    logic [1:0] got, exp_v;
    int c;
    restart(11'd9, 11'd3, 11'd0, 1'b0, 6'd0);
    for (int j = 1; j <= 40; j++) begin
      c = j - 1;
      if (c == 4) begin
        duty_in = {11'd0, 11'd7};
        duty_wr = 2'b01;
      end else if (c == 19) begin
        duty_in = {11'd0, 11'd5};
        duty_wr = 2'b01;
      end else begin
        duty_wr = 2'b00;
      end
      step();
      exp_v = {j % 10 == 0, (c % 10) < dv[c / 10]};
      got   = {period_start, pwm_hi[0]};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL duty_update j=%0d: got %b expected %b", j, got, exp_v);
      end
    end
    duty_wr = 2'b00;
  endtask

  task automatic test_extremes();
    logic [3:0] got, exp_v;
    restart(11'd9, 11'd0, 11'd10, 1'b0, 6'd3);
    for (int j = 1; j <= 25; j++) begin
      step();
      exp_v = (j < 4) ? 4'b0000 : 4'b0110;
      got   = {pwm_hi[0], pwm_lo[0], pwm_hi[1], pwm_lo[1]};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL extremes j=%0d: got %b expected %b", j, got, exp_v);
      end
    end
  endtask

  task automatic test_swallow();
    logic [1:0] got, exp_v;
    int p;
    restart(11'd9, 11'd2, 11'd0, 1'b0, 6'd5);
    for (int j = 1; j <= 30; j++) begin
      step();
      p = j % 10;
      exp_v = {1'b0, (p >= 8) || (p == 0)};
      got   = {pwm_hi[0], pwm_lo[0]};
      checks++;
      if (got !== exp_v) begin
        errors++;
        $display("FAIL swallow j=%0d: got %b expected %b", j, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_enable();
    restart(11'd9, 11'd5, 11'd0, 1'b0, 6'd0);
    step(); step(); step();
    checks++;
    if (pwm_hi[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hi: got %b expected 1", pwm_hi[0]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({period_start, pwm_hi, pwm_lo} !== 5'b00000) begin
      errors++;
      $display("FAIL async_reset: got %b expected 00000", {period_start, pwm_hi, pwm_lo});
    end
    #2;
    rst = 1'b0;
    step();
    checks++;
    if ({period_start, pwm_hi[0]} !== 2'b10) begin
      errors++;
      $display("FAIL reset_restart: got %b expected 10", {period_start, pwm_hi[0]});
    end
    step();
    checks++;
    if (period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart_pulse: got %b expected 0", period_start);
    end

    restart(11'd9, 11'd5, 11'd0, 1'b0, 6'd0);
    step(); step(); step();
    checks++;
    if (pwm_hi[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_disable_hi: got %b expected 1", pwm_hi[0]);
    end
    en = 1'b0;
    step();
    checks++;
    if ({period_start, pwm_hi, pwm_lo} !== 5'b00000) begin
      errors++;
      $display("FAIL disable_outputs: got %b expected 00000", {period_start, pwm_hi, pwm_lo});
    end
    checks++;
    if (dut.cnt !== 11'd0) begin
      errors++;
      $display("FAIL disable_cnt: got %0d expected 0", dut.cnt);
    end
    en = 1'b1;
    step();
    checks++;
    if ({period_start, pwm_hi[0], pwm_lo[0]} !== 3'b100) begin
      errors++;
      $display("FAIL enable_restart: got %b expected 100", {period_start, pwm_hi[0], pwm_lo[0]});
    end
    step();
    checks++;
    if ({period_start, pwm_hi[0], pwm_lo[0]} !== 3'b010) begin
      errors++;
      $display("FAIL enable_first_hi: got %b expected 010", {period_start, pwm_hi[0], pwm_lo[0]});
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    center    = 1'b0;
    period_in = '0;
    period_wr = 1'b0;
    duty_in   = '0;
    duty_wr   = '0;
    deadtime  = '0;
    step();
    step();
    test_reset();
    rst = 1'b0;
    step();
    test_edge();
    test_center();
    test_back_to_back();
    test_extremes();
    test_swallow();
    test_reset_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_multi_dt.md
Name: pwm_multi_dt

Overview:
Parametrised multi-channel PWM generator. It is the next generation of the team's single-channel 11-bit free-running PWM.
- Adds: programmable period, edge- or centre-aligned counting, double-buffered duty/period updates at the period boundary, and per-channel complementary outputs with dead-time insertion.
- Sits between the motor/LED control loop (duty writer) and the output pads / gate drivers.

Parameters:
WIDTH, 11, bit width of counter, period and duty values
NCH, 2, number of PWM channels
DT_W, 6, bit width of the dead-time value

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  run enable; 0 holds counter at 0 and forces outputs low
center  input  1  mode: 0 = edge-aligned (up-count), 1 = centre-aligned (up/down)
period_in  input  WIDTH  period value, written to the period shadow register
period_wr  input  1  load period_in into the period shadow register
duty_in  input  NCH*WIDTH  packed duty values; channel i uses bits [i*WIDTH +: WIDTH]
duty_wr  input  NCH  per-channel load of the duty shadow register
deadtime  input  DT_W  dead-time in clk cycles, applied to all channels; sampled live
pwm_hi  output  NCH  high-side drive, registered
pwm_lo  output  NCH  low-side drive, registered
period_start  output  1  one-cycle pulse at the start of each PWM period, registered

Behaviour:
- Reset (async, rst=1):
  - cnt=0, dir=up.
  - period_act and period_sh = all ones.
  - duty_act and duty_sh = 0.
  - pwm_hi=0, pwm_lo=0 (both off), period_start=0.
  - Dead-time counters = 0.
  - Reset mid-period drops all outputs immediately.
- Counter, edge mode:
  - cnt counts 0..period_act, then wraps to 0.
  - Period length = period_act+1 cycles.
- Counter, centre mode:
  - cnt counts up 0..period_act, then down to 0, with dir toggling at each endpoint.
  - Period length = 2*period_act cycles.
  - period_act=0 holds cnt at 0 in either mode.
- Boundary:
  - Defined as the cycle in which cnt will become 0 next clock, on an up-start.
  - On that edge: period_act<=period_sh, duty_act[i]<=duty_sh[i], and period_start=1 for one cycle, aligned with cnt==0.
- Shadow writes:
  - period_wr / duty_wr[i] update the shadow register on the next edge.
  - A write coinciding with a boundary edge lands in the shadow only. The active register takes the pre-write shadow value; the new value applies at the following boundary.
  - Mode change takes effect only at a boundary: center is sampled at the boundary, and dir is reset to up.
- Compare: raw[i] = (cnt < duty_act[i]), unsigned, WIDTH bits.
  - duty_act=0: raw is always 0.
  - duty_act > period_act: raw is always 1 (100%). No wrap or overflow cases exist.
- Dead-time, per channel:
  - Any raw[i] edge immediately deasserts the currently-on output on the next clock.
  - The opposite output asserts only after raw[i] has been stable for deadtime cycles.
  - Latency:
    - turn-off = 1 cycle after the raw change.
    - turn-on = deadtime+1 cycles after the raw change.
  - deadtime=0: pwm_hi=raw, pwm_lo=~raw, with 1-cycle latency. This is identical to the legacy block behaviour.
  - If raw toggles again before the dead-time expires, the counter restarts and neither output asserts. A pulse shorter than deadtime is swallowed.
  - pwm_hi & pwm_lo is never 1, under any input sequence.
- Enable:
  - en=0: cnt=0, dir=up, period_start=0, both outputs 0, dead-time counters cleared. Shadow writes are still accepted.
  - en 0->1: the first cycle is treated as a boundary, so shadows are loaded and period_start pulses. The outputs then pass through dead-time normally; the low side also waits deadtime.

Decomposition:
- Shared package pwm_pkg:
  - mode typedef: enum logic {PWM_EDGE, PWM_CENTER}.
  - Default constants: PWM_WIDTH=11, PWM_NCH=2, PWM_DT_W=6.
  - Direction typedef: enum {UP, DOWN}.
- Sub-module pwm_deadtime: one per channel via generate.
  - Inputs: clk, rst, en, raw, deadtime.
  - Outputs: hi, lo.
  - Contains the DT_W counter and the small state machine: OFF_BOTH, HI_ON, LO_ON, WAIT.
- Counter, shadows and compare live in the top.

Test Plan:
- Reset, then en=1, center=0, period=9, duty0=3, deadtime=0 -> pwm_hi[0] high 3 of every 10 cycles, 1 cycle after cnt; period_start every 10 cycles.
- Centre mode, period=8, duty0=4, deadtime=2 -> 16-cycle period with a symmetric hi pulse. Each hi rising edge is 3 cycles after the raw rise and lo falls 1 cycle after it; lo and hi are never both 1.
- duty_wr with duty0=7 issued mid-period, and again on the exact boundary cycle with 5 -> old duty holds until the boundary, then 7 applies; 5 applies one period later.
- duty0=0 and duty1=period+1 (period=9) -> pwm_hi[0] constantly 0 / pwm_lo[0] 1; pwm_hi[1] constantly 1 / pwm_lo[1] 0, both after the initial dead-time.
- deadtime=5, duty0=2, period=9 -> the 2-cycle high pulse is swallowed: pwm_hi[0] stays 0, and pwm_lo[0] drops for the raw-high window plus dead-time.
- Assert rst for 1 cycle mid-pulse, and separately drop en mid-period -> all outputs 0 immediately (rst, asynchronously) or on the next edge (en); cnt=0; restart begins with a period_start pulse.
